// File: rtl/if_stage_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : if_stage_pkg                                                |
// | Shared MIPS fetch-stage definitions: next-PC select codes, opcode and |
// | function codes used with the hazard unit, and target helpers.         |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package if_stage_pkg;

  // next-PC select codes driven by the hazard unit
  localparam logic [1:0] c_PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] c_PC_SEL_BR  = 2'd1;
  localparam logic [1:0] c_PC_SEL_J   = 2'd2;
  localparam logic [1:0] c_PC_SEL_JR  = 2'd3;

  // opcode / function codes shared with the hazard unit
  localparam logic [5:0] c_OP_RTYPE   = 6'h00;
  localparam logic [5:0] c_OP_J       = 6'h02;
  localparam logic [5:0] c_OP_BEQ     = 6'h04;
  localparam logic [5:0] c_OP_LW      = 6'h23;
  localparam logic [5:0] c_FUNC_JR    = 6'h08;

  // sign-extended, word-scaled branch displacement of an I-type instruction
  function automatic logic [31:0] branch_offset(input logic [31:0] inst);
    return {{14{inst[15]}}, inst[15:0], 2'b00};
  endfunction

  // pseudo-direct jump target: region bits of PC+4, 26-bit word index
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] inst);
    return {pc4[31:28], inst[25:0], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : if_id_reg                                                   |
// | IF/ID pipeline register. Priority: rst, hold (write_en=0), flush,     |
// | load. Hold beats flush so a redirecting instruction caught in a       |
// | load-use stall is kept and re-evaluated on the following cycle.       |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_write_en,
  input  logic        i_flush,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_valid;

  // rst / hold / flush / load priority chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= NOP_INST;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (!i_write_en) begin
      r_inst  <= r_inst;
      r_pc4   <= r_pc4;
      r_valid <= r_valid;
    end else if (i_flush) begin
      r_inst  <= NOP_INST;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_inst  <= i_inst;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : if_stage                                                    |
// | MIPS instruction-fetch stage: PC register, branch/jump target adders, |
// | next-PC mux and the IF/ID pipeline register.                          |
// | Optional: define IF_PERF_CNT_EN to add stall/flush/fetch counters.    |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
`ifdef IF_PERF_CNT_EN
  ,
  parameter int          CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic [1:0]       pc_sel,
  input  logic             IF_ID_write_en,
  input  logic             IF_ID_flush,
  input  logic [31:0]      jr_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      IF_ID_inst,
  output logic [31:0]      IF_ID_pc4,
  output logic             IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fetch_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_next_pc;

  // targets are formed from the instruction sitting in IF/ID (decided in ID)
  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = IF_ID_pc4 + branch_offset(IF_ID_inst);
  assign w_j_tgt  = jump_target(IF_ID_pc4, IF_ID_inst);

  // next-PC select; jr_target passes through with its low bits untouched
  always_comb begin
    w_next_pc = w_pc4;
    case (pc_sel)
      c_PC_SEL_SEQ: w_next_pc = w_pc4;
      c_PC_SEL_BR:  w_next_pc = w_br_tgt;
      c_PC_SEL_J:   w_next_pc = w_j_tgt;
      c_PC_SEL_JR:  w_next_pc = jr_target;
      default:      w_next_pc = w_pc4;
    endcase
  end

  // PC register; select is irrelevant while pc_write is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (pc_write) begin
      r_pc <= w_next_pc;
    end
  end

  assign pc        = r_pc;
  assign imem_addr = r_pc;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_write_en (IF_ID_write_en),
    .i_flush    (IF_ID_flush),
    .i_inst     (imem_rdata),
    .i_pc4      (w_pc4),
    .o_inst     (IF_ID_inst),
    .o_pc4      (IF_ID_pc4),
    .o_valid    (IF_ID_valid)
  );

`ifdef IF_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_flush_eff;
  logic             w_fetch_eff;

  // flush only counts when it is not masked by an IF/ID hold
  assign w_flush_eff = IF_ID_write_en &  IF_ID_flush;
  assign w_fetch_eff = IF_ID_write_en & ~IF_ID_flush;

  // free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fetch_cnt <= '0;
    end else begin
      if (!pc_write)   r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      if (w_flush_eff) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      if (w_fetch_eff) r_fetch_cnt <= r_fetch_cnt + c_CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign fetch_cnt = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_if_stage                                                 |
// | Self-checking bench for if_stage: directed scenarios followed by      |
// | random hazard-control traffic against a behavioural fetch model.      |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        IF_ID_write_en;
  logic        IF_ID_flush;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, fetch_cnt;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  // instruction memory: 256 words, index mixes in the top address byte
  logic [31:0] mem [0:255];

  function automatic logic [7:0] mem_idx(input logic [31:0] a);
    return a[9:2] ^ a[31:24];
  endfunction

  assign imem_rdata = mem[mem_idx(imem_addr)];

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .pc_sel         (pc_sel),
    .IF_ID_write_en (IF_ID_write_en),
    .IF_ID_flush    (IF_ID_flush),
    .jr_target      (jr_target),
    .imem_rdata     (imem_rdata),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .IF_ID_inst     (IF_ID_inst),
    .IF_ID_pc4      (IF_ID_pc4),
    .IF_ID_valid    (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .fetch_cnt      (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  logic [31:0] m_stall, m_flush, m_fetch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // apply one cycle of controls, advance the model, compare everything
  task automatic step(input logic r, input logic pw, input logic [1:0] sel,
                      input logic we, input logic fl, input logic [31:0] jr);
    logic [31:0] npc, tgt;
    rst = r; pc_write = pw; pc_sel = sel;
    IF_ID_write_en = we; IF_ID_flush = fl; jr_target = jr;
    case (sel)
      2'd0:    tgt = m_pc + 32'd4;
      2'd1:    tgt = m_pc4 + ({{16{m_inst[15]}}, m_inst[15:0]} * 32'd4);
      2'd2:    tgt = (m_pc4 & 32'hF000_0000) | ({6'd0, m_inst[25:0]} * 32'd4);
      default: tgt = jr;
    endcase
    npc = pw ? tgt : m_pc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'd0; m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_stall = 0; m_flush = 0; m_fetch = 0;
    end else begin
      if (!pw) m_stall++;
      if (we && fl) begin
        m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_flush++;
      end else if (we) begin
        m_inst = mem[mem_idx(m_pc)]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_fetch++;
      end
      m_pc = npc;
    end
    #1;
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("IF_ID_inst", IF_ID_inst, m_inst);
    check("IF_ID_pc4", IF_ID_pc4, m_pc4);
    check("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    check("fetch_cnt", fetch_cnt, m_fetch);
`endif
  endtask

  task automatic seq();
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'd0);
  endtask

  logic [31:0] s_pc, s_inst, s_pc4;
  logic        s_valid;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h03] = 32'h1000_0003;               // beq, imm +3
    mem[8'h13] = {6'h02, 26'h40};             // j 0x40 (word index)
    m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0;
    m_stall = 0; m_flush = 0; m_fetch = 0;

    // reset
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("rst_inst", IF_ID_inst, 32'h0);
    seq(); check("seq_pc4", pc, 32'h4); check("seq_ifpc4", IF_ID_pc4, 32'h4);
    seq(); check("seq_pc8", pc, 32'h8);
    seq(); check("seq_pcC", pc, 32'hC);
    seq(); check("br_ifpc4", IF_ID_pc4, 32'h10);

    // taken branch, positive offset
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 32'd0);
    check("br_pos_pc", pc, 32'h1C);
    check("br_pos_valid", {31'd0, IF_ID_valid}, 32'd0);

    // taken branch, offset -1
    mem[8'h03] = 32'h1000_FFFF;
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 32'hC);
    seq();
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 32'd0);
    check("br_neg_pc", pc, 32'hC);

    // jr
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 32'h200);
    check("jr_pc", pc, 32'h200);
    check("jr_addr", imem_addr, 32'h200);
    check("jr_valid", {31'd0, IF_ID_valid}, 32'd0);

    // jump with region bits from IF_ID_pc4
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 32'h1000_000C);
    seq();
    check("j_ifpc4", IF_ID_pc4, 32'h1000_0010);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 32'd0);
    check("j_pc", pc, 32'h1000_0100);
    check("j_valid", {31'd0, IF_ID_valid}, 32'd0);

    // stall: hold beats flush and redirect
    seq();
    s_pc = pc; s_inst = IF_ID_inst; s_pc4 = IF_ID_pc4; s_valid = IF_ID_valid;
    step(1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 32'd0);
    check("stall_pc", pc, s_pc);
    check("stall_inst", IF_ID_inst, s_inst);
    check("stall_pc4", IF_ID_pc4, s_pc4);
    check("stall_valid", {31'd0, IF_ID_valid}, {31'd0, s_valid});
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 32'd0);
    check("stall_rel_pc", pc, s_pc4 + {{14{s_inst[15]}}, s_inst[15:0], 2'b00});

    // wrap and reset during stall
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 32'hFFFF_FFFC);
    seq();
    check("wrap_pc", pc, 32'h0);
    check("wrap_ifpc4", IF_ID_pc4, 32'h0);
    seq();
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0);
    check("rst_stall_pc", pc, 32'h0);
    check("rst_stall_valid", {31'd0, IF_ID_valid}, 32'd0);

    // random hazard traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] jr;
      jr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) == 0),
           jr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
